// File: rtl/ltt_lt_mult.sv
// ltt_lt_mult: forms A^-1 = K^T * K from a 6x6 lower-triangular Q16.16 K.
// Only the upper triangle (r <= c) is evaluated. Each element is mirrored into
// both [r][c] and [c][r] of a work array. The work array is copied to
// `inverse` in a single cycle when the run finishes. One pipelined multiplier
// and one accumulator do all the arithmetic.
// Build option: define ACCUM_SAT_EN for saturating accumulation (the
// accumulator is widened by 4 bits and results are clamped); without it the
// sums wrap modulo 2^WIDTH.
module ltt_lt_mult #(
  parameter int MULT_LATENCY = 4,
  parameter int WIDTH        = 36
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] lt_inverse [6][6],
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] inverse [6][6]
);

`ifdef ACCUM_SAT_EN
  localparam int AW = WIDTH + 4;
`else
  localparam int AW = WIDTH;
`endif
  localparam int LAST = MULT_LATENCY - 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t                  state;
  logic [2:0]              idx_r, idx_c, idx_k;
  logic signed [WIDTH-1:0] k_copy [6][6];
  logic signed [WIDTH-1:0] work [6][6];
  logic                    issue;
  logic                    pipe_busy;
  logic signed [WIDTH-1:0] op_a, op_b;
  logic signed [2*WIDTH-1:0] prod_full;
  logic signed [AW-1:0]    prod_trim;
  logic signed [AW-1:0]    acc, acc_sum;
  logic signed [WIDTH-1:0] wr_val;
  logic                    unused_prod;

  logic                    pipe_valid [MULT_LATENCY];
  logic                    pipe_first [MULT_LATENCY];
  logic                    pipe_last  [MULT_LATENCY];
  logic [2:0]              pipe_row   [MULT_LATENCY];
  logic [2:0]              pipe_col   [MULT_LATENCY];
  logic signed [AW-1:0]    pipe_prod  [MULT_LATENCY];

  assign issue     = en && (state == ISSUE);
  assign op_a      = k_copy[idx_k][idx_r];
  assign op_b      = k_copy[idx_k][idx_c];
  assign prod_full = (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b);

`ifdef ACCUM_SAT_EN
  localparam logic signed [2*WIDTH-17:0] PROD_MAX = {{(2*WIDTH-16-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [2*WIDTH-17:0] PROD_MIN = ~PROD_MAX;
  localparam logic signed [AW-1:0]       RES_MAX  = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0]       RES_MIN  = ~RES_MAX;
  logic signed [2*WIDTH-17:0] prod_shift;

  assign prod_shift  = prod_full[2*WIDTH-1:16];
  assign unused_prod = ^prod_full[15:0];

  // Clamp the >>16 product into the widened accumulator range.
  always_comb begin
    prod_trim = prod_shift[AW-1:0];
    if (prod_shift > PROD_MAX)
      prod_trim = PROD_MAX[AW-1:0];
    else if (prod_shift < PROD_MIN)
      prod_trim = PROD_MIN[AW-1:0];
  end

  // Clamp the finished element into the WIDTH-bit result range.
  always_comb begin
    wr_val = acc_sum[WIDTH-1:0];
    if (acc_sum > RES_MAX)
      wr_val = RES_MAX[WIDTH-1:0];
    else if (acc_sum < RES_MIN)
      wr_val = RES_MIN[WIDTH-1:0];
  end
`else
  // Plain wrap: keep bits [WIDTH+15:16] of the full product.
  assign prod_trim   = prod_full[WIDTH+15:16];
  assign wr_val      = acc_sum;
  assign unused_prod = ^{prod_full[2*WIDTH-1:WIDTH+16], prod_full[15:0]};
`endif

  // Products still travelling through the pipeline, excluding the one that
  // is consumed at this edge; once clear, the work array is final next cycle.
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < LAST; i++)
      pipe_busy = pipe_busy | pipe_valid[i];
  end

  // Multiplier pipeline: stage 0 captures the issued product, later stages shift.
  generate
    for (genvar gi = 0; gi < MULT_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        // Load a new product with its element tags when issuing.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            pipe_valid[0] <= 1'b0;
            pipe_first[0] <= 1'b0;
            pipe_last[0]  <= 1'b0;
            pipe_row[0]   <= 3'd0;
            pipe_col[0]   <= 3'd0;
            pipe_prod[0]  <= '0;
          end else if (en) begin
            pipe_valid[0] <= issue;
            pipe_first[0] <= (idx_k == idx_c);
            pipe_last[0]  <= (idx_k == 3'd5);
            pipe_row[0]   <= idx_r;
            pipe_col[0]   <= idx_c;
            pipe_prod[0]  <= prod_trim;
          end
        end
      end else begin : g_tail
        // Advance the product one stage per enabled cycle.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            pipe_valid[gi] <= 1'b0;
            pipe_first[gi] <= 1'b0;
            pipe_last[gi]  <= 1'b0;
            pipe_row[gi]   <= 3'd0;
            pipe_col[gi]   <= 3'd0;
            pipe_prod[gi]  <= '0;
          end else if (en) begin
            pipe_valid[gi] <= pipe_valid[gi-1];
            pipe_first[gi] <= pipe_first[gi-1];
            pipe_last[gi]  <= pipe_last[gi-1];
            pipe_row[gi]   <= pipe_row[gi-1];
            pipe_col[gi]   <= pipe_col[gi-1];
            pipe_prod[gi]  <= pipe_prod[gi-1];
          end
        end
      end
    end
  endgenerate

  assign acc_sum = (pipe_first[LAST] ? {AW{1'b0}} : acc) + pipe_prod[LAST];

  // Accumulate products; the last product of an element writes both mirror slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++)
          work[i][j] <= '0;
    end else if (en && pipe_valid[LAST]) begin
      acc <= acc_sum;
      if (pipe_last[LAST]) begin
        work[pipe_row[LAST]][pipe_col[LAST]] <= wr_val;
        work[pipe_col[LAST]][pipe_row[LAST]] <= wr_val;
      end
    end
  end

  // Sequencer: capture K, walk (c, r, k), drain, then publish the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      idx_r <= 3'd0;
      idx_c <= 3'd0;
      idx_k <= 3'd0;
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++) begin
          k_copy[i][j]  <= '0;
          inverse[i][j] <= '0;
        end
    end else if (en) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 6; i++)
              for (int j = 0; j < 6; j++)
                k_copy[i][j] <= lt_inverse[i][j];
            busy  <= 1'b1;
            idx_r <= 3'd0;
            idx_c <= 3'd0;
            idx_k <= 3'd0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (idx_k != 3'd5) begin
            idx_k <= idx_k + 3'd1;
          end else if (idx_r != idx_c) begin
            idx_r <= idx_r + 3'd1;
            idx_k <= idx_c;
          end else if (idx_c != 3'd5) begin
            idx_c <= idx_c + 3'd1;
            idx_r <= 3'd0;
            idx_k <= idx_c + 3'd1;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!pipe_busy)
            state <= FINISH;
        end
        FINISH: begin
          for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
              inverse[i][j] <= work[i][j];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ltt_lt_mult.sv
// Testbench for ltt_lt_mult: directed runs checked against a matrix-level
// model of K^T * K (upper K triangle masked to zero), plus literal expectations.
module tb_ltt_lt_mult;
  localparam int W = 36;
  localparam int L = 4;

  typedef logic [5:0][5:0][W-1:0] mat_t;

  logic                clk;
  logic                reset_n;
  logic                en;
  logic                start;
  logic signed [W-1:0] lt_in  [6][6];
  logic                busy;
  logic                done;
  logic signed [W-1:0] inv_out [6][6];

  int   n_total;
  int   n_pass;
  int   done_count;
  mat_t exp_inv;
  mat_t model_q[$];

  ltt_lt_mult #(.MULT_LATENCY(L), .WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .start     (start),
    .lt_inverse(lt_in),
    .busy      (busy),
    .done      (done),
    .inverse   (inv_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full matrix product over masked K, per-product >>16.
  function automatic mat_t model(input mat_t k);
    mat_t res;
    logic signed [71:0] a, b, t, s;
`ifdef ACCUM_SAT_EN
    logic signed [71:0] sat_p, res_p;
    sat_p = (72'sd1 <<< 39) - 72'sd1;
    res_p = (72'sd1 <<< 35) - 72'sd1;
`endif
    res = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        s = '0;
        for (int i = 0; i < 6; i++) begin
          a = $signed(k[i][r]);
          b = $signed(k[i][c]);
          if (i < r) a = '0;
          if (i < c) b = '0;
          t = (a * b) >>> 16;
`ifdef ACCUM_SAT_EN
          if (t > sat_p) t = sat_p;
          else if (t < -sat_p - 72'sd1) t = -sat_p - 72'sd1;
`endif
          s = s + t;
        end
`ifdef ACCUM_SAT_EN
        s = 72'($signed(s[39:0]));
        if (s > res_p) s = res_p;
        else if (s < -res_p - 72'sd1) s = -res_p - 72'sd1;
`endif
        res[r][c] = s[W-1:0];
      end
    return res;
  endfunction

  function automatic mat_t diag(input logic [W-1:0] v);
    mat_t m;
    m = '0;
    for (int i = 0; i < 6; i++) m[i][i] = v;
    return m;
  endfunction

  // Per-cycle compare: inverse must equal the last published model result.
  always @(negedge clk) begin : cmp_proc
    bit ok;
    int br, bc;
    ok = 1'b1;
    br = 0;
    bc = 0;
    if (!reset_n) begin
      exp_inv = '0;
      model_q.delete();
    end else if (done) begin
      done_count++;
      if (model_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done t=%0t got done=1 want done=0", $time);
      end else begin
        exp_inv = model_q.pop_front();
      end
    end
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        if (ok && (inv_out[i][j] !== exp_inv[i][j])) begin
          ok = 1'b0;
          br = i;
          bc = j;
        end
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL inverse_cmp t=%0t [%0d][%0d] got %0d want %0d",
                  $time, br, bc, inv_out[br][bc], $signed(exp_inv[br][bc]));
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) begin
      n_pass++;
      $display("check %s: got %0d", name, $signed(got));
    end else begin
      $display("FAIL %s got %0d want %0d", name, $signed(got), $signed(want));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_k(input mat_t m);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        lt_in[i][j] = m[i][j];
  endtask

  // Present K and pulse start; returns just after the accept edge.
  task automatic start_run(input mat_t m, input string name);
    set_k(m);
    model_q.push_back(model(m));
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_busy"}, 64'(busy), 64'd1);
  endtask

  // Count enabled+disabled edges from acceptance until done is seen.
  task automatic wait_done(input int already, input int want, input string name);
    int n;
    bit seen;
    n = already;
    seen = 1'b0;
    for (int guard = 0; guard < 400 && !seen; guard++) begin
      tick();
      n++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL %s_timeout got no done want done at edge %0d", name, want);
    end else begin
      check({name, "_latency"}, 64'(n), 64'(want));
      check({name, "_busy_end"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    mat_t ident, dbl, kc, kov, mk;
    int dc;
    n_total = 0;
    n_pass = 0;
    done_count = 0;
    exp_inv = '0;
    reset_n = 1'b0;
    en = 1'b1;
    start = 1'b0;
    set_k('0);

    ident = diag(36'd65536);
    dbl = diag(36'd131072);
    dbl[0][5] = 36'd12345;
    dbl[2][4] = 36'd999999;
    kc = ident;
    kc[1][0] = -36'sd32768;
    kov = ident;
    kov[0][0] = 36'h4_0000_0000;

    repeat (3) tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_inv00", 64'(inv_out[0][0]), 64'd0);
    reset_n = 1'b1;
    tick();

    mk = model(kc);
    check("model_kc00", 64'($signed(mk[0][0])), 64'd81920);
    check("model_kc01", 64'($signed(mk[0][1])), 64'(-32768));
    mk = model(dbl);
    check("model_dbl05", 64'($signed(mk[0][5])), 64'd0);

    // Identity
    start_run(ident, "ident");
    wait_done(0, 57 + L, "ident");
    check("ident_00", 64'(inv_out[0][0]), 64'd65536);
    check("ident_01", 64'(inv_out[0][1]), 64'd0);
    check("ident_55", 64'(inv_out[5][5]), 64'd65536);

    // Start accepted in the done cycle; diag 2.0 with garbage above diagonal
    start_run(dbl, "dbl");
    wait_done(0, 57 + L, "dbl");
    check("dbl_33", 64'(inv_out[3][3]), 64'd262144);
    check("dbl_05", 64'(inv_out[0][5]), 64'd0);

    // Single off-diagonal term
    start_run(kc, "kc");
    wait_done(0, 57 + L, "kc");
    check("kc_00", 64'(inv_out[0][0]), 64'd81920);
    check("kc_01", 64'(inv_out[0][1]), 64'(-32768));
    check("kc_10", 64'(inv_out[1][0]), 64'(-32768));
    check("kc_11", 64'(inv_out[1][1]), 64'd65536);

    // en low for 3 cycles mid-ISSUE
    start_run(kc, "engap");
    repeat (10) tick();
    en = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    wait_done(13, 60 + L, "engap");
    check("engap_00", 64'(inv_out[0][0]), 64'd81920);

    // Second start while busy must be ignored
    start_run(ident, "ign");
    repeat (4) tick();
    set_k(dbl);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_busy", 64'(busy), 64'd1);
    wait_done(5, 57 + L, "ign");
    check("ign_00", 64'(inv_out[0][0]), 64'd65536);

    // Abort by reset at T20
    start_run(kc, "abort");
    repeat (4) tick();
    set_k(ident);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_inv00", 64'(inv_out[0][0]), 64'd0);
    dc = done_count;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (80) tick();
    check("abort_no_done", 64'(done_count - dc), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);
    start_run(kc, "fresh");
    wait_done(0, 57 + L, "fresh");
    check("fresh_00", 64'(inv_out[0][0]), 64'd81920);

    // Overflow of the diagonal product
    mk = model(kov);
    start_run(kov, "ovf");
    wait_done(0, 57 + L, "ovf");
`ifdef ACCUM_SAT_EN
    check("model_ovf00", 64'($signed(mk[0][0])), 64'h7_FFFF_FFFF);
    check("ovf_00", 64'(inv_out[0][0]), 64'h7_FFFF_FFFF);
`else
    check("model_ovf00", 64'($signed(mk[0][0])), 64'd0);
    check("ovf_00", 64'(inv_out[0][0]), 64'd0);
`endif
    check("ovf_11", 64'(inv_out[1][1]), 64'd65536);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ltt_lt_mult.md
Name: ltt_lt_mult

Overview:
Final stage of the matrix-inverse path, directly downstream of the lower-triangular inverse stage.
- Takes K = L^-1, a 6x6 lower-triangular Q16.16 matrix, and forms A^-1 = K^T * K.
- Result is symmetric. Only the upper triangle is computed (r <= c); each result is written to both [r][c] and [c][r].
- Self-sequenced with a start/done handshake, a single pipelined multiplier and one accumulator.

Parameters:
MULT_LATENCY, 4, pipeline depth of the internal signed 36x36 multiplier in cycles (1..8).
WIDTH, 36, element width; Q(WIDTH-16).16 signed fixed point (65536 = 1.0).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
en  in  1  global enable; low freezes all state including the multiplier pipeline
start  in  1  request; sampled only when en=1 and busy=0
lt_inverse  in  6x6xWIDTH  K matrix, [row][col]; captured on the start-accept edge
busy  out  1  high from the start-accept edge until done
done  out  1  one-cycle pulse when inverse updates
inverse  out  6x6xWIDTH  A^-1 result, [row][col]; registered

Behaviour:
Reset (async, reset_n=0):
- busy=0, done=0, inverse all zero.
- Work array, accumulator and pipeline valid bits cleared; FSM to IDLE.
- Reset mid-operation aborts the run; no partial result ever reaches inverse.

FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: on start=1 (en=1), capture lt_inverse into a local copy; busy<=1; indices c=0, r=0, k=0; go to ISSUE.
- ISSUE: one product per enabled cycle, K[k][r]*K[k][c].
  - k runs c..5 (max(r,c)=c since r<=c).
  - Then r advances 0..c; then c advances 0..5.
  - Total 56 products. Each product is tagged first/last for its element.
  - After the 56th issue, go to DRAIN.
- DRAIN: wait until the pipeline valid bits are empty, then go to FINISH.
- FINISH: inverse <= work array (atomic, all 36 entries); done<=1 for one cycle; busy<=0; go to IDLE.

Accumulation:
- A product tagged first loads the accumulator; others add to it.
- A product tagged last writes acc+product to work[r][c] and work[c][r].

Arithmetic:
- Full 72-bit signed product; keep bits [WIDTH+15:16] (arithmetic >>16, truncation toward -inf).
- Accumulate modulo 2^WIDTH (see Optional Feature).

Timing (en held high, start accepted at edge T0):
- Issues at edges T1..T56.
- Last element written at T56+MULT_LATENCY.
- done high for the cycle following edge T57+MULT_LATENCY.
- Each en=0 cycle delays every later event by exactly one cycle.

Boundaries:
- start while busy=1: ignored, no effect on the in-flight run.
- start in the cycle done is high: accepted (busy already 0).
- inverse holds its previous value for the whole run.
- Upper-triangle input entries (col > row) are ignored; they are never multiplied.

Optional Feature:
ACCUM_SAT_EN
- Defined: accumulator widened to WIDTH+4 bits; each shifted product is clamped to WIDTH+4 bits; the written result is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Undefined: plain WIDTH-bit wrap-around as above.

Test Plan:
- K = identity (diag 65536) -> inverse = identity (diag 65536, off-diagonals 0); done at T57+4 = T61.
- K diag all 131072 (2.0) -> inverse diag 262144, all off-diagonals 0.
- K = identity except K[1][0]=-32768 -> inverse[0][0]=81920, inverse[0][1]=inverse[1][0]=-32768, inverse[1][1]=65536, rest identity.
- en low for 3 cycles mid-ISSUE -> done at T64, result bit-identical to the uninterrupted run.
- Second start during busy, and reset_n low at T20 -> second start ignored; after the reset, busy=0, inverse=0, no done pulse; a fresh start completes normally.
- K[0][0]=2^34, identity elsewhere:
  - Without ACCUM_SAT_EN: inverse[0][0]=0 (wrap).
  - With ACCUM_SAT_EN: inverse[0][0]=2^35-1.
